// File: rtl/ram_bus_pkg.sv
// ram_bus_pkg: shared types for the ram arbiter and its round-robin chooser.
package ram_bus_pkg;

    typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_IO} state_e;
    typedef enum logic {M_CPU, M_IO} m_id_e;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: 2-way round-robin chooser; on a tie the master that did not own last wins.
module rr_pick
    import ram_bus_pkg::*;
(
    input  logic [1:0] req_i,
    input  m_id_e      last_i,
    output m_id_e      win_o
);

    // req_i[0] is the cpu, req_i[1] the io side
    assign win_o = (&req_i) ? ((last_i == M_CPU) ? M_IO : M_CPU)
                            : (req_i[1] ? M_IO : M_CPU);

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port ram between the cpu and the dma/io master,
// round-robin with a per-owner burst limit.
module ram_arbiter
    import ram_bus_pkg::*;
#(
    parameter int SZ        = 8,
    parameter int WSZ       = 8,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cpu_req,
    input  logic           cpu_w_notr,
    input  logic [SZ-1:0]  cpu_addr,
    input  logic [WSZ-1:0] cpu_wdata,
    output logic           cpu_gnt,
    output logic           cpu_ack,
    output logic [WSZ-1:0] cpu_rdata,
    input  logic           io_req,
    input  logic           io_w_notr,
    input  logic [SZ-1:0]  io_addr,
    input  logic [WSZ-1:0] io_wdata,
    output logic           io_gnt,
    output logic           io_ack,
    output logic [WSZ-1:0] io_rdata,
    output logic [SZ-1:0]  ram_addr,
    output logic           ram_w_notr,
    inout  wire  [WSZ-1:0] ram_data
);

    localparam int CW = $clog2(MAX_BURST + 1);

    state_e         state_q, state_d;
    m_id_e          last_q, last_d, win;
    logic [CW-1:0]  burst_q, burst_d;
    logic [SZ-1:0]  addr_q;
    logic           cpu_ack_q, io_ack_q;
    logic [WSZ-1:0] cpu_rdata_q, io_rdata_q;
    logic           own_io, own_req, oth_req, acc, at_lim;

    rr_pick u_pick (
        .req_i  ({io_req, cpu_req}),
        .last_i (last_q),
        .win_o  (win)
    );

    assign own_io     = state_q == OWN_IO;
    assign own_req    = own_io ? io_req : cpu_req;
    assign oth_req    = own_io ? cpu_req : io_req;
    assign acc        = (state_q != IDLE) && own_req;
    assign at_lim     = burst_q == CW'(MAX_BURST - 1);
    assign ram_w_notr = acc && (own_io ? io_w_notr : cpu_w_notr);
    // the address bus keeps its last value whenever no access is in flight
    assign ram_addr   = acc ? (own_io ? io_addr : cpu_addr) : addr_q;
    assign ram_data   = ram_w_notr ? (own_io ? io_wdata : cpu_wdata) : {WSZ{1'bz}};
    assign cpu_gnt    = state_q == OWN_CPU;
    assign io_gnt     = own_io;
    assign cpu_ack    = cpu_ack_q;
    assign io_ack     = io_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign io_rdata   = io_rdata_q;

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        last_d  = last_q;
        if (state_q == IDLE) begin
            if (cpu_req || io_req) begin
                state_d = (win == M_IO) ? OWN_IO : OWN_CPU;
                burst_d = '0;
            end
        end else if (!own_req) begin
            // releasing owner always passes through IDLE, even at the burst limit
            state_d = IDLE;
            last_d  = own_io ? M_IO : M_CPU;
            burst_d = '0;
        end else if (at_lim) begin
            burst_d = '0;
            if (oth_req) begin
                state_d = own_io ? OWN_CPU : OWN_IO;
                last_d  = own_io ? M_IO : M_CPU;
            end
        end else begin
            burst_d = burst_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            burst_q     <= '0;
            last_q      <= M_IO;
            addr_q      <= '0;
            cpu_ack_q   <= 1'b0;
            io_ack_q    <= 1'b0;
            cpu_rdata_q <= '0;
            io_rdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            last_q    <= last_d;
            addr_q    <= ram_addr;
            cpu_ack_q <= acc && !own_io;
            io_ack_q  <= acc && own_io;
            if (acc && !own_io && !cpu_w_notr) cpu_rdata_q <= ram_data;
            if (acc && own_io && !io_w_notr) io_rdata_q <= ram_data;
        end
    end

endmodule
